// File: rtl/sync_src_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_src_serializer_if
// Description : Bundles the wide-word input handshake and the beat-wide
//               enqueue port toward the source side of a 1-deep sync FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_src_serializer_if #(
  parameter int dataWidth = 8,
  parameter int beats     = 4
);
  logic                          iVALID;
  logic [dataWidth*beats-1:0]    iDATA;
  logic                          iREADY;
  logic                          oENQ;
  logic [dataWidth-1:0]          oDATA;
  logic                          oLAST;
  logic                          oFULL_N;

  // Environment side: offers words and reports FIFO space
  modport master (
    output iVALID, iDATA, oFULL_N,
    input  iREADY, oENQ, oDATA, oLAST
  );

  // Serializer side: accepts words and emits beats
  modport slave (
    input  iVALID, iDATA, oFULL_N,
    output iREADY, oENQ, oDATA, oLAST
  );
endinterface
`default_nettype wire

// File: rtl/sync_src_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sync_src_serializer
// Description : Buffers up to two wide words and streams each one, LSB beat
//               first, into the source side of a 1-deep sync FIFO. Counts
//               fully sent words.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_src_serializer #(
  parameter int dataWidth = 8,
  parameter int beats     = 4,
  parameter int cntWidth  = 16
) (
  input  wire logic                 sCLK,
  input  wire logic                 sRST,
  sync_src_serializer_if.slave      bus,
  output logic                      sBUSY,
  output logic [cntWidth-1:0]       sWORDS
);

  localparam int c_WORD_W = dataWidth * beats;
  localparam int c_BIDX_W = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [c_BIDX_W-1:0] c_LAST_BEAT = c_BIDX_W'(beats - 1);

  generate
    if (beats < 2 || beats > 16) begin : g_bad_beats
      $error("sync_src_serializer: beats must be in 2..16");
    end
  endgenerate

  // Two-entry word buffer and its bookkeeping
  logic [c_WORD_W-1:0] entry_q [2];
  logic                rd_ptr_q,   rd_ptr_d;
  logic                wr_ptr_q,   wr_ptr_d;
  logic [1:0]          count_q,    count_d;
  logic [c_BIDX_W-1:0] beat_idx_q, beat_idx_d;
  logic [cntWidth-1:0] words_q,    words_d;

  logic w_push;
  logic w_enq;
  logic w_last_beat;
  logic w_pop;

  // Ready depends on occupancy only, so no combinational path from iVALID
  assign bus.iREADY  = (count_q != 2'd2) && !sRST;
  assign w_push      = bus.iVALID && bus.iREADY;

  // A beat is offered whenever a word is buffered and the FIFO has room
  assign w_enq       = (count_q != 2'd0) && bus.oFULL_N && !sRST;
  assign w_last_beat = (beat_idx_q == c_LAST_BEAT);
  assign w_pop       = w_enq && w_last_beat;

  assign bus.oENQ    = w_enq;
  assign bus.oDATA   = entry_q[rd_ptr_q][32'(beat_idx_q) * dataWidth +: dataWidth];
  assign bus.oLAST   = w_last_beat && (count_q != 2'd0);
  assign sBUSY       = (count_q != 2'd0);
  assign sWORDS      = words_q;

  // Next-state for pointers, beat index, occupancy and sent-word counter
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    beat_idx_d = beat_idx_q;
    words_d    = words_q;

    if (w_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (w_enq) begin
      if (w_last_beat) begin
        beat_idx_d = '0;
        rd_ptr_d   = ~rd_ptr_q;
        words_d    = words_q + cntWidth'(1);
      end else begin
        beat_idx_d = beat_idx_q + c_BIDX_W'(1);
      end
    end

    // Simultaneous push and final-beat pop leaves occupancy unchanged
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset; partial words are dropped
  always_ff @(posedge sCLK) begin
    if (sRST) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      beat_idx_q <= '0;
      words_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      beat_idx_q <= beat_idx_d;
      words_q    <= words_d;
    end
  end

  // Word storage is not reset; contents are only read while count is non-zero
  always_ff @(posedge sCLK) begin
    if (w_push) begin
      entry_q[wr_ptr_q] <= bus.iDATA;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_src_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_src_serializer
// Description : Directed self-checking bench for sync_src_serializer
//               (dataWidth=8, beats=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_src_serializer;

  logic        sCLK = 1'b0;
  logic        sRST;
  logic        sBUSY;
  logic [15:0] sWORDS;

  int n_checks = 0;
  int n_pass   = 0;

  sync_src_serializer_if #(.dataWidth(8), .beats(4)) bus ();

  sync_src_serializer #(
    .dataWidth(8),
    .beats    (4),
    .cntWidth (16)
  ) dut (
    .sCLK  (sCLK),
    .sRST  (sRST),
    .bus   (bus),
    .sBUSY (sBUSY),
    .sWORDS(sWORDS)
  );

  always #5 sCLK = ~sCLK;

  task automatic tick();
    @(posedge sCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    sRST        = 1'b1;
    bus.iVALID  = 1'b0;
    bus.iDATA   = '0;
    bus.oFULL_N = 1'b1;
    tick();
    tick();
    sRST = 1'b0;
  endtask

  task automatic test_reset();
    sRST        = 1'b1;
    bus.iVALID  = 1'b0;
    bus.iDATA   = '0;
    bus.oFULL_N = 1'b1;
    tick();
    bus.iVALID = 1'b1;
    bus.iDATA  = 32'h12345678;
    settle();
    n_checks++; if (bus.iREADY !== 1'b0) $display("FAIL reset_iready: got %b expected 0", bus.iREADY); else n_pass++;
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL reset_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    tick();
    sRST       = 1'b0;
    bus.iVALID = 1'b0;
    settle();
    n_checks++; if (bus.oLAST !== 1'b0) $display("FAIL post_reset_olast: got %b expected 0", bus.oLAST); else n_pass++;
    n_checks++; if (sBUSY !== 1'b0) $display("FAIL post_reset_sbusy: got %b expected 0", sBUSY); else n_pass++;
    n_checks++; if (sWORDS !== 16'd0) $display("FAIL post_reset_swords: got %0d expected 0", sWORDS); else n_pass++;
    n_checks++; if (bus.iREADY !== 1'b1) $display("FAIL post_reset_iready: got %b expected 1", bus.iREADY); else n_pass++;
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL post_reset_oenq: got %b expected 0", bus.oENQ); else n_pass++;
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    bus.iVALID = 1'b1;
    bus.iDATA  = 32'hDDCCBBAA;
    settle();
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL single_empty_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    tick();
    bus.iVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++; if (bus.oENQ !== 1'b1) $display("FAIL single_oenq[%0d]: got %b expected 1", i, bus.oENQ); else n_pass++;
      n_checks++; if (bus.oDATA !== exp_b[i]) $display("FAIL single_odata[%0d]: got %h expected %h", i, bus.oDATA, exp_b[i]); else n_pass++;
      n_checks++; if (bus.oLAST !== (i == 3)) $display("FAIL single_olast[%0d]: got %b expected %b", i, bus.oLAST, (i == 3)); else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL single_done_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    n_checks++; if (sBUSY !== 1'b0) $display("FAIL single_done_sbusy: got %b expected 0", sBUSY); else n_pass++;
    n_checks++; if (sWORDS !== 16'd1) $display("FAIL single_swords: got %0d expected 1", sWORDS); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    do_reset();
    bus.iVALID = 1'b1;
    bus.iDATA  = 32'h44332211;
    tick();
    bus.iDATA  = 32'h88776655;
    for (int i = 0; i < 8; i++) begin
      exp_d = 8'((i + 1) * 17);
      settle();
      if (i == 0) begin
        n_checks++; if (bus.iREADY !== 1'b1) $display("FAIL b2b_iready: got %b expected 1", bus.iREADY); else n_pass++;
      end
      n_checks++; if (bus.oENQ !== 1'b1) $display("FAIL b2b_oenq[%0d]: got %b expected 1", i, bus.oENQ); else n_pass++;
      n_checks++; if (bus.oDATA !== exp_d) $display("FAIL b2b_odata[%0d]: got %h expected %h", i, bus.oDATA, exp_d); else n_pass++;
      n_checks++; if (bus.oLAST !== (i == 3 || i == 7)) $display("FAIL b2b_olast[%0d]: got %b expected %b", i, bus.oLAST, (i == 3 || i == 7)); else n_pass++;
      tick();
      bus.iVALID = 1'b0;
    end
    settle();
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL b2b_done_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    n_checks++; if (sWORDS !== 16'd2) $display("FAIL b2b_swords: got %0d expected 2", sWORDS); else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] exp_b [3];
    exp_b = '{8'hBB, 8'hCC, 8'hDD};
    do_reset();
    bus.iVALID = 1'b1;
    bus.iDATA  = 32'hDDCCBBAA;
    tick();
    bus.iVALID = 1'b0;
    settle();
    n_checks++; if (bus.oDATA !== 8'hAA) $display("FAIL stall_first: got %h expected aa", bus.oDATA); else n_pass++;
    tick();
    bus.oFULL_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL stall_oenq[%0d]: got %b expected 0", i, bus.oENQ); else n_pass++;
      n_checks++; if (bus.oDATA !== 8'hBB) $display("FAIL stall_odata[%0d]: got %h expected bb", i, bus.oDATA); else n_pass++;
      tick();
    end
    bus.oFULL_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (bus.oENQ !== 1'b1) $display("FAIL resume_oenq[%0d]: got %b expected 1", i, bus.oENQ); else n_pass++;
      n_checks++; if (bus.oDATA !== exp_b[i]) $display("FAIL resume_odata[%0d]: got %h expected %h", i, bus.oDATA, exp_b[i]); else n_pass++;
      n_checks++; if (bus.oLAST !== (i == 2)) $display("FAIL resume_olast[%0d]: got %b expected %b", i, bus.oLAST, (i == 2)); else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (sWORDS !== 16'd1) $display("FAIL stall_swords: got %0d expected 1", sWORDS); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] words [3];
    logic [31:0] w;
    logic [7:0]  exp_d;
    words = '{32'h44332211, 32'h88776655, 32'h0D0C0B0A};
    do_reset();
    bus.oFULL_N = 1'b0;
    bus.iVALID  = 1'b1;
    bus.iDATA   = words[0];
    tick();
    bus.iDATA   = words[1];
    settle();
    n_checks++; if (bus.iREADY !== 1'b1) $display("FAIL bp_second_iready: got %b expected 1", bus.iREADY); else n_pass++;
    tick();
    bus.iDATA   = words[2];
    settle();
    n_checks++; if (bus.iREADY !== 1'b0) $display("FAIL bp_full_iready: got %b expected 0", bus.iREADY); else n_pass++;
    tick();
    settle();
    n_checks++; if (bus.iREADY !== 1'b0) $display("FAIL bp_full_iready2: got %b expected 0", bus.iREADY); else n_pass++;
    bus.oFULL_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      w     = words[i / 4];
      exp_d = 8'(w >> (8 * (i % 4)));
      settle();
      if (i < 4) begin
        n_checks++; if (bus.iREADY !== 1'b0) $display("FAIL bp_iready_busy[%0d]: got %b expected 0", i, bus.iREADY); else n_pass++;
      end
      if (i == 4) begin
        n_checks++; if (bus.iREADY !== 1'b1) $display("FAIL bp_third_accept: got %b expected 1", bus.iREADY); else n_pass++;
      end
      n_checks++; if (bus.oENQ !== 1'b1) $display("FAIL bp_oenq[%0d]: got %b expected 1", i, bus.oENQ); else n_pass++;
      n_checks++; if (bus.oDATA !== exp_d) $display("FAIL bp_odata[%0d]: got %h expected %h", i, bus.oDATA, exp_d); else n_pass++;
      tick();
      if (i == 4) bus.iVALID = 1'b0;
    end
    settle();
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL bp_done_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    n_checks++; if (sWORDS !== 16'd3) $display("FAIL bp_swords: got %0d expected 3", sWORDS); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    bus.iVALID = 1'b1;
    bus.iDATA  = 32'h44332211;
    tick();
    bus.iVALID = 1'b0;
    settle();
    n_checks++; if (bus.oDATA !== 8'h11) $display("FAIL mid_beat0: got %h expected 11", bus.oDATA); else n_pass++;
    tick();
    settle();
    n_checks++; if (bus.oDATA !== 8'h22) $display("FAIL mid_beat1: got %h expected 22", bus.oDATA); else n_pass++;
    tick();
    sRST = 1'b1;
    settle();
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL mid_rst_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    n_checks++; if (bus.iREADY !== 1'b0) $display("FAIL mid_rst_iready: got %b expected 0", bus.iREADY); else n_pass++;
    tick();
    sRST = 1'b0;
    settle();
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL mid_after_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    n_checks++; if (sBUSY !== 1'b0) $display("FAIL mid_after_sbusy: got %b expected 0", sBUSY); else n_pass++;
    n_checks++; if (sWORDS !== 16'd0) $display("FAIL mid_after_swords: got %0d expected 0", sWORDS); else n_pass++;
    bus.iVALID = 1'b1;
    bus.iDATA  = 32'h88776655;
    tick();
    bus.iVALID = 1'b0;
    settle();
    n_checks++; if (bus.oENQ !== 1'b1) $display("FAIL mid_new_oenq: got %b expected 1", bus.oENQ); else n_pass++;
    n_checks++; if (bus.oDATA !== 8'h55) $display("FAIL mid_new_odata: got %h expected 55", bus.oDATA); else n_pass++;
    n_checks++; if (bus.oLAST !== 1'b0) $display("FAIL mid_new_olast: got %b expected 0", bus.oLAST); else n_pass++;
  endtask

  task automatic test_ignore_when_full();
    logic [7:0] exp_d;
    do_reset();
    bus.oFULL_N = 1'b0;
    bus.iVALID  = 1'b1;
    bus.iDATA   = 32'h44332211;
    tick();
    bus.iDATA   = 32'h88776655;
    tick();
    bus.iDATA   = 32'hEEEEEEEE;
    settle();
    n_checks++; if (bus.iREADY !== 1'b0) $display("FAIL ign_iready: got %b expected 0", bus.iREADY); else n_pass++;
    n_checks++; if (sBUSY !== 1'b1) $display("FAIL ign_sbusy: got %b expected 1", sBUSY); else n_pass++;
    tick();
    tick();
    bus.iVALID  = 1'b0;
    bus.oFULL_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_d = 8'((i + 1) * 17);
      settle();
      n_checks++; if (bus.oENQ !== 1'b1) $display("FAIL ign_oenq[%0d]: got %b expected 1", i, bus.oENQ); else n_pass++;
      n_checks++; if (bus.oDATA !== exp_d) $display("FAIL ign_odata[%0d]: got %h expected %h", i, bus.oDATA, exp_d); else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (bus.oENQ !== 1'b0) $display("FAIL ign_done_oenq: got %b expected 0", bus.oENQ); else n_pass++;
    n_checks++; if (sBUSY !== 1'b0) $display("FAIL ign_done_sbusy: got %b expected 0", sBUSY); else n_pass++;
    n_checks++; if (sWORDS !== 16'd2) $display("FAIL ign_swords: got %0d expected 2", sWORDS); else n_pass++;
  endtask

  initial begin
    sRST        = 1'b1;
    bus.iVALID  = 1'b0;
    bus.iDATA   = '0;
    bus.oFULL_N = 1'b1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_reset_mid_word();
    test_ignore_when_full();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_src_serializer.md
SYNC_SRC_SERIALIZER -- requirements
Module: sync_src_serializer

Interface
REQ-001 SHALL have parameter dataWidth, default 8: beat width in bits, equal to the downstream 1-deep sync FIFO data width.
REQ-002 SHALL have parameter beats, default 4: beats per input word; legal range 2..16.
REQ-003 SHALL have parameter cntWidth, default 16: width of the sent-word counter.
REQ-004 SHALL have port sCLK, input, 1 bit: source-domain clock; all state updates on its rising edge.
REQ-005 SHALL have port sRST, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port iVALID, input, 1 bit: wide input word present.
REQ-007 SHALL have port iDATA, input, dataWidth*beats bits: wide input word.
REQ-008 SHALL have port iREADY, output, 1 bit: block accepts iDATA this cycle.
REQ-009 SHALL have port oENQ, output, 1 bit: enqueue strobe to the sync FIFO source side.
REQ-010 SHALL have port oDATA, output, dataWidth bits: current beat.
REQ-011 SHALL have port oLAST, output, 1 bit: current beat is the final beat of its word.
REQ-012 SHALL have port oFULL_N, input, 1 bit: sync FIFO not-full, taken from its source-side full flag.
REQ-013 SHALL have port sBUSY, output, 1 bit: buffer non-empty.
REQ-014 SHALL have port sWORDS, output, cntWidth bits: count of fully sent words, wrapping modulo 2^cntWidth.

Function
REQ-015 SHALL hold a 2-entry wide-word buffer: entry storage, rdPtr, wrPtr, and an occupancy count of 0..2.
REQ-016 SHALL drive iREADY = (count != 2) && !sRST, combinational from registers only, with no path from iVALID.
REQ-017 SHALL write iDATA into entry[wrPtr] when iVALID && iREADY, incrementing wrPtr (mod 2) and count.
REQ-018 SHALL drive oDATA = entry[rdPtr] bits [beatIdx*dataWidth +: dataWidth], LSB beat first; beatIdx is a register of width ceil(log2(beats)).
REQ-019 SHALL drive oENQ = (count != 0) && oFULL_N && !sRST.
REQ-020 SHALL drive oLAST = (beatIdx == beats-1) && (count != 0).
REQ-021 SHALL advance beatIdx by 1 on a cycle where oENQ=1 and beatIdx < beats-1.
REQ-022 SHALL, on a cycle where oENQ=1 and beatIdx = beats-1, do all of the following: clear beatIdx to 0, increment rdPtr (mod 2), decrement count, and increment sWORDS.
REQ-023 SHALL, on simultaneous push and final-beat pop, leave count unchanged and update both pointers.
REQ-024 SHALL send beats of consecutive buffered words with no idle cycle between them while oFULL_N=1.
REQ-025 SHALL hold beatIdx, oDATA, and buffer contents stable while oFULL_N=0; the stalled beat SHALL be re-presented unchanged.
REQ-026 SHALL make a word accepted at edge N present its first beat (oENQ=1 if oFULL_N=1) in the cycle after edge N when the buffer was empty.
REQ-027 SHALL never assert oENQ while oFULL_N=0, and never drop or duplicate a beat.
REQ-028 SHALL drive sBUSY = (count != 0).

Reset
REQ-029 SHALL, while sRST=1 at a sCLK edge, clear count, rdPtr, wrPtr, beatIdx, and sWORDS to 0; buffer data SHALL be don't-care.
REQ-030 SHALL, during sRST=1, drive iREADY=0 and oENQ=0; after reset, oLAST=0, sBUSY=0, and sWORDS=0.
REQ-031 SHALL, on reset mid-word, discard partial words; the first post-reset word SHALL start at beat 0.

Verification (dataWidth=8, beats=4)
REQ-032 SHALL cover: push 0xDDCCBBAA, oFULL_N=1 -> oENQ=1 for 4 cycles, oDATA AA,BB,CC,DD, oLAST only on DD, sWORDS=1.
REQ-033 SHALL cover: push 0x44332211 and 0x88776655 back-to-back -> 8 consecutive oENQ beats 11..88 with no bubble, sWORDS=2.
REQ-034 SHALL cover: oFULL_N=0 for 3 cycles while oDATA=BB -> oENQ=0, oDATA stays BB, then CC and DD follow with no loss.
REQ-035 SHALL cover: oFULL_N=0 and 3 words offered -> iREADY=0 after 2 accepted; the 3rd is accepted in the cycle after the first word's final beat.
REQ-036 SHALL cover: sRST=1 for 1 cycle at beatIdx=2 -> next cycle oENQ=0, sBUSY=0, sWORDS=0; next word starts with its LSB beat.
REQ-037 SHALL cover: iVALID=1 while iREADY=0 -> word ignored, no change to count or to the beat sequence.
